// File: rtl/sram_ctrl_pkg.sv
// sram_ctrl_pkg: default widths and response-queue depth shared by the SRAM access controller.
package sram_ctrl_pkg;
    localparam int DEF_DATA_WIDTH  = 32;
    localparam int DEF_ADDR_WIDTH  = 12;
    localparam int DEF_WMASK_WIDTH = DEF_DATA_WIDTH / 8;
    localparam int RSP_FIFO_DEPTH  = 2;
endpackage

// File: rtl/sram_rsp_fifo.sv
// sram_rsp_fifo: two-entry read-response queue with wrapping pointers and an occupancy counter.
module sram_rsp_fifo
    import sram_ctrl_pkg::*;
#(
    parameter int WIDTH = DEF_DATA_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_push,
    input  logic             i_pop,
    input  logic [WIDTH-1:0] i_din,
    output logic [WIDTH-1:0] o_dout,
    output logic             o_full,
    output logic             o_empty
);
    localparam int PW = $clog2(RSP_FIFO_DEPTH);
    logic [WIDTH-1:0] r_mem [RSP_FIFO_DEPTH];
    logic [PW-1:0]    r_wptr;
    logic [PW-1:0]    r_rptr;
    logic [1:0]       r_count;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < RSP_FIFO_DEPTH; i++) r_mem[i] <= '0;
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (i_push) begin
                r_mem[r_wptr] <= i_din;
                r_wptr        <= r_wptr + PW'(1);
            end
            if (i_pop) r_rptr <= r_rptr + PW'(1);
            r_count <= r_count + 2'(i_push) - 2'(i_pop);
        end
    end
    assign o_dout  = r_mem[r_rptr];
    assign o_full  = r_count == 2'(RSP_FIFO_DEPTH);
    assign o_empty = r_count == 2'd0;
endmodule

// File: rtl/sram_access_ctrl.sv
// sram_access_ctrl: valid/ready front end for a single-port SRAM macro with one-cycle read latency,
// returning read data in order through a two-entry response queue.
module sram_access_ctrl
    import sram_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH  = DEF_ADDR_WIDTH,
    parameter int WMASK_WIDTH = DEF_WMASK_WIDTH
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   req_valid,
    output logic                   req_ready,
    input  logic                   req_we,
    input  logic [WMASK_WIDTH-1:0] req_wmask,
    input  logic [ADDR_WIDTH-1:0]  req_addr,
    input  logic [DATA_WIDTH-1:0]  req_wdata,
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic [DATA_WIDTH-1:0]  rsp_rdata,
    output logic                   sram_we,
    output logic [WMASK_WIDTH-1:0] sram_wmask,
    output logic [ADDR_WIDTH-1:0]  sram_addr,
    output logic [DATA_WIDTH-1:0]  sram_din,
    input  logic [DATA_WIDTH-1:0]  sram_dout
);
    logic       r_rd_inflight;
    logic       w_fire;
    logic       w_pop;
    logic       w_full;
    logic       w_empty;
    logic [1:0] w_occ;
    logic [2:0] w_level;
    assign w_fire    = req_valid && req_ready;
    assign w_pop     = rsp_valid && rsp_ready;
    assign w_occ     = w_full ? 2'd2 : (w_empty ? 2'd0 : 2'd1);
    // Reads already committed (queued or in the macro) less the one leaving this cycle.
    assign w_level   = {1'b0, w_occ} + {2'b0, r_rd_inflight} - {2'b0, w_pop};
    assign req_ready = !rst && (w_level < 3'(RSP_FIFO_DEPTH));
    assign rsp_valid = !w_empty;
    assign sram_we    = req_we && w_fire;
    assign sram_wmask = req_wmask;
    assign sram_addr  = req_addr;
    assign sram_din   = req_wdata;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_rd_inflight <= 1'b0;
        else     r_rd_inflight <= w_fire && !req_we;
    end
    sram_rsp_fifo #(.WIDTH(DATA_WIDTH)) u_rsp_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (r_rd_inflight),
        .i_pop   (w_pop),
        .i_din   (sram_dout),
        .o_dout  (rsp_rdata),
        .o_full  (w_full),
        .o_empty (w_empty)
    );
endmodule

// File: tb/tb_sram_access_ctrl.sv
// tb_sram_access_ctrl: directed table, corner sequences and random traffic against an ordered-response model.
module tb_sram_access_ctrl;
    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_ready, req_we;
    logic [3:0]  req_wmask;
    logic [11:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid, rsp_ready;
    logic [31:0] rsp_rdata;
    logic        sram_we;
    logic [3:0]  sram_wmask;
    logic [11:0] sram_addr;
    logic [31:0] sram_din, sram_dout;

    sram_access_ctrl dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_wmask(req_wmask), .req_addr(req_addr), .req_wdata(req_wdata), .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .sram_we(sram_we), .sram_wmask(sram_wmask),
        .sram_addr(sram_addr), .sram_din(sram_din), .sram_dout(sram_dout)
    );

    always #5 clk = ~clk;

    // Macro model: byte-masked write, registered read.
    logic [31:0] smem [0:4095];
    always @(posedge clk) begin
        if (sram_we)
            for (int i = 0; i < 4; i++)
                if (sram_wmask[i]) smem[sram_addr][8*i +: 8] <= sram_din[8*i +: 8];
        sram_dout <= smem[sram_addr];
    end

    typedef struct { logic [31:0] data; int due; } rsp_t;
    rsp_t        q[$];
    logic [31:0] gm [0:4095];
    int          cyc = 0;
    int          n_chk = 0;
    int          n_err = 0;
    logic        s_ready, s_we, s_rv;
    logic [31:0] s_rd;

    typedef struct {
        logic v, we; logic [3:0] m; logic [11:0] a; logic [31:0] d; logic rr;
        logic e_rdy, e_we, e_rv; logic [31:0] e_rd;
    } vec_t;
    vec_t tbl [22];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic step(input logic v, input logic we, input logic [3:0] m, input logic [11:0] a,
                        input logic [31:0] d, input logic rr);
        logic m_rv, m_pop, m_rdy, m_fire;
        @(negedge clk);
        req_valid = v; req_we = we; req_wmask = m; req_addr = a; req_wdata = d; rsp_ready = rr;
        #1;
        s_ready = req_ready; s_we = sram_we; s_rv = rsp_valid; s_rd = rsp_rdata;
        m_rv   = q.size() > 0 && q[0].due <= cyc;
        m_pop  = m_rv && rr;
        m_rdy  = (q.size() - int'(m_pop)) < 2;
        m_fire = v && m_rdy;
        chk("req_ready", 64'(s_ready), 64'(m_rdy));
        chk("sram_we", 64'(s_we), 64'(we && m_fire));
        chk("rsp_valid", 64'(s_rv), 64'(m_rv));
        if (m_rv) chk("rsp_rdata", 64'(s_rd), 64'(q[0].data));
        chk("passthru", 64'({sram_wmask, sram_addr, sram_din}), 64'({m, a, d}));
        if (m_pop) void'(q.pop_front());
        if (m_fire && we)
            for (int i = 0; i < 4; i++) if (m[i]) gm[a][8*i +: 8] = d[8*i +: 8];
        if (m_fire && !we) q.push_back('{gm[a], cyc + 2});
        cyc++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 4'h0, 12'h000, 32'h0, 1);
    endtask

    initial begin
        tbl[0]  = '{1, 1, 4'hF, 12'h005, 32'hDEADBEEF, 1, 1, 1, 0, 32'h0};
        tbl[1]  = '{1, 0, 4'hF, 12'h005, 32'h0,        1, 1, 0, 0, 32'h0};
        tbl[2]  = '{0, 0, 4'h0, 12'h000, 32'h0,        1, 1, 0, 0, 32'h0};
        tbl[3]  = '{0, 0, 4'h0, 12'h000, 32'h0,        1, 1, 0, 1, 32'hDEADBEEF};
        tbl[4]  = '{0, 0, 4'h0, 12'h000, 32'h0,        1, 1, 0, 0, 32'h0};
        tbl[5]  = '{1, 1, 4'hF, 12'h010, 32'h11223344, 1, 1, 1, 0, 32'h0};
        tbl[6]  = '{1, 1, 4'h5, 12'h010, 32'hAABBCCDD, 1, 1, 1, 0, 32'h0};
        tbl[7]  = '{1, 0, 4'h0, 12'h010, 32'h0,        1, 1, 0, 0, 32'h0};
        tbl[8]  = '{0, 0, 4'h0, 12'h000, 32'h0,        1, 1, 0, 0, 32'h0};
        tbl[9]  = '{0, 0, 4'h0, 12'h000, 32'h0,        1, 1, 0, 1, 32'h11BB33DD};
        tbl[10] = '{0, 0, 4'h0, 12'h000, 32'h0,        1, 1, 0, 0, 32'h0};
        tbl[11] = '{1, 1, 4'hF, 12'h001, 32'hA1A10001, 1, 1, 1, 0, 32'h0};
        tbl[12] = '{1, 1, 4'hF, 12'h002, 32'hA2A20002, 1, 1, 1, 0, 32'h0};
        tbl[13] = '{1, 1, 4'hF, 12'h003, 32'hA3A30003, 1, 1, 1, 0, 32'h0};
        tbl[14] = '{1, 0, 4'h0, 12'h001, 32'h0,        0, 1, 0, 0, 32'h0};
        tbl[15] = '{1, 0, 4'h0, 12'h002, 32'h0,        0, 1, 0, 0, 32'h0};
        tbl[16] = '{1, 0, 4'h0, 12'h003, 32'h0,        0, 0, 0, 1, 32'hA1A10001};
        tbl[17] = '{1, 0, 4'h0, 12'h003, 32'h0,        0, 0, 0, 1, 32'hA1A10001};
        tbl[18] = '{1, 0, 4'h0, 12'h003, 32'h0,        1, 1, 0, 1, 32'hA1A10001};
        tbl[19] = '{0, 0, 4'h0, 12'h000, 32'h0,        1, 1, 0, 1, 32'hA2A20002};
        tbl[20] = '{0, 0, 4'h0, 12'h000, 32'h0,        1, 1, 0, 1, 32'hA3A30003};
        tbl[21] = '{0, 0, 4'h0, 12'h000, 32'h0,        1, 1, 0, 0, 32'h0};

        rst = 1'b1;
        req_valid = 1'b1; req_we = 1'b1; req_wmask = 4'hF; req_addr = 12'h0; req_wdata = 32'h0;
        rsp_ready = 1'b1;
        #1;
        chk("rst_req_ready", 64'(req_ready), 64'(0));
        chk("rst_rsp_valid", 64'(rsp_valid), 64'(0));
        chk("rst_sram_we", 64'(sram_we), 64'(0));
        chk("rst_rsp_rdata", 64'(rsp_rdata), 64'(0));
        @(negedge clk);
        rst = 1'b0; req_valid = 1'b0; req_we = 1'b0;

        for (int i = 0; i < 22; i++) begin
            step(tbl[i].v, tbl[i].we, tbl[i].m, tbl[i].a, tbl[i].d, tbl[i].rr);
            chk($sformatf("tbl%0d_ready", i), 64'(s_ready), 64'(tbl[i].e_rdy));
            chk($sformatf("tbl%0d_we", i), 64'(s_we), 64'(tbl[i].e_we));
            chk($sformatf("tbl%0d_rvalid", i), 64'(s_rv), 64'(tbl[i].e_rv));
            if (tbl[i].e_rv) chk($sformatf("tbl%0d_rdata", i), 64'(s_rd), 64'(tbl[i].e_rd));
        end

        for (int i = 0; i < 8; i++) step(1, 1, 4'hF, 12'h020 + 12'(i), $urandom, 1);
        for (int i = 0; i < 10; i++) begin
            if (i < 8) step(1, 0, 4'h0, 12'h020 + 12'(i), 32'h0, 1);
            else       step(0, 0, 4'h0, 12'h000, 32'h0, 1);
            if (i < 8) chk("b2b_ready", 64'(s_ready), 64'(1));
            chk("b2b_rsp_per_cycle", 64'(s_rv), 64'(i >= 2));
        end

        step(1, 0, 4'h0, 12'h001, 32'h0, 0);
        step(1, 0, 4'h0, 12'h002, 32'h0, 0);
        step(0, 0, 4'h0, 12'h000, 32'h0, 0);
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b0; req_addr = 12'h003; rsp_ready = 1'b1;
        #1;
        chk("pre_rst_rsp_valid", 64'(rsp_valid), 64'(1));
        rst = 1'b1;
        #1;
        chk("midrst_rsp_valid", 64'(rsp_valid), 64'(0));
        chk("midrst_req_ready", 64'(req_ready), 64'(0));
        chk("midrst_sram_we", 64'(sram_we), 64'(0));
        chk("midrst_rsp_rdata", 64'(rsp_rdata), 64'(0));
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0; req_valid = 1'b0;
        q.delete();
        step(0, 0, 4'h0, 12'h000, 32'h0, 1);
        chk("ready_after_rst", 64'(s_ready), 64'(1));
        for (int i = 0; i < 10; i++) begin
            step(0, 0, 4'h0, 12'h000, 32'h0, 1);
            chk("idle_sram_we", 64'(s_we), 64'(0));
            chk("idle_rsp_valid", 64'(s_rv), 64'(0));
        end

        for (int i = 0; i < 16; i++) step(1, 1, 4'hF, 12'(i), $urandom, 1);
        idle(2);
        for (int i = 0; i < 500; i++)
            step(($urandom % 4) != 0, 1'($urandom), 4'($urandom), 12'($urandom % 16), $urandom,
                 ($urandom % 4) != 0);
        idle(4);
        chk("drained", 64'(q.size()), 64'(0));

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
